gctr_stream: RTL and testbench
==============================

// Module: gctr_stream
// PURPOSE
//  Streaming, parametrised successor of the fixed-width GCTR stage. Accepts a message of
//  arbitrary bit length one 128-bit block at a time, generates counter blocks with inc_S,
//  issues them to an external pipelined AES core, XORs the keystream and emits ciphertext.
//  Supports a partial final block, counter wrap and AES back-pressure, with bounded in-flight
//  blocks. Sits between the GCM controller and the AES core; GHASH consumes its output.
// PARAMETERS
//  S          32  increment width of inc_S; 1..128
//  LEN_WIDTH  32  width of msg_len_bits (message length in bits)
//  DEPTH      4   max in-flight blocks, counted from input accept to output handshake; power of 2, >=2
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous reset, active-high
//  start         in   1           1-cycle pulse; latches icb_in and msg_len_bits when IDLE
//  icb_in        in   128         initial counter block CB1
//  msg_len_bits  in   LEN_WIDTH   message length in bits; 0 is legal
//  din_valid     in   1           input block valid
//  din_ready     out  1           input block accepted when din_valid && din_ready
//  din           in   128         plaintext block X_i, MSB-aligned
//  aes_req_valid out  1           counter block to AES core valid
//  aes_req_ready in   1           AES core can take a request
//  aes_req_block out  128         CB_i
//  aes_rsp_valid in   1           keystream valid; in order; no back-pressure
//  aes_rsp_block in   128         CIPH_K(CB_i)
//  dout_valid    out  1           output block valid
//  dout_ready    in   1           output consumer ready
//  dout          out  128         Y_i; bits below dout_nbits are forced to 0
//  dout_last     out  1           marks Y_n
//  dout_nbits    out  8           valid bits in dout: 128, or 1..128 on the last block
//  busy          out  1           high from the cycle after start until done
//  done          out  1           1-cycle pulse, one cycle after the Y_n handshake (or after start if len==0)
//  err           out  1           sticky: aes_rsp_valid arrived with no outstanding request; cleared by start
// BEHAVIOUR
//  Reset: state IDLE; din_ready, aes_req_valid, dout_valid, dout_last, busy, done and err all 0;
//   aes_req_block, dout and dout_nbits 0; FIFOs empty; all counters 0.
//  FSM: IDLE -start-> RUN (n = ceil(len/128) > 0) | FIN (len == 0). RUN -> DRAIN when block n is
//   accepted. DRAIN -> FIN on the Y_n handshake. FIN -> IDLE after 1 cycle, asserting done.
//  start outside IDLE is ignored.
//  Credit: inflight = accepted - output handshakes; 0..DEPTH.
//  din_ready = aes_req_valid = (state==RUN) && aes_req_ready && (inflight < DEPTH) && din_valid gating:
//   din_ready excludes din_valid, and aes_req_valid = din_ready && din_valid.
//   An accept pushes din to the data FIFO and issues aes_req_block = current CB in the same cycle.
//  Counter: CB1 = icb_in; after each accept, CB = {CB[127:S], CB[S-1:0]+1 mod 2^S}.
//   The low S bits wrap FF..F -> 0 with no carry into the upper bits.
//  Response: aes_rsp_valid pops the data FIFO; Y = X ^ rsp, masked for the last block;
//   Y is pushed to the output FIFO. dout_valid rises the cycle after aes_rsp_valid (1-cycle latency).
//  Last block: r = len mod 128; if r != 0 then dout_nbits = r and dout[127-r:0] = 0.
//  Accept and output in the same cycle: inflight is unchanged. An output FIFO overflow is impossible by credit.
//  aes_rsp_valid with outstanding==0 (e.g. a stale response after rst): response dropped, err set.
//  Reset mid-operation clears everything immediately; the integrator resets the AES core on the same rst.
//  Block counter width is LEN_WIDTH-6; lengths whose block count wraps CB are legal (wrap rule above).
// STRUCTURE
//  gcm_pkg: BLOCK_W=128, state encoding (IDLE/RUN/DRAIN/FIN), function inc_s(cb, S),
//   function mask_tail(blk, nbits).
//  Sub-module gctr_fifo (WIDTH, DEPTH): synchronous FIFO with full/empty/count, async active-high rst;
//   instantiated twice (data FIFO: 128 bits; output FIFO: 128+1+8 bits).
// TESTING
//  1. len=384, ICB=0x..00000001, AES model 3-cycle latency -> 3 outputs, CBs ..01/..02/..03, NIST TC3 ciphertext, done once.
//  2. len=100 -> one output, dout_nbits=100, dout[27:0]=0, dout_last=1.
//  3. ICB low word 0xFFFFFFFE, len=512 -> CB low words FFFFFFFE, FFFFFFFF, 00000000, 00000001; upper 96 bits unchanged.
//  4. dout_ready=0 for 20 cycles with DEPTH=4 -> exactly 4 accepts, then din_ready=0; resumes after readiness returns; no loss or reorder.
//  5. len=0 -> no aes_req, done one cycle after start; start while busy ignored.
//  6. rst asserted mid-RUN, then a stale aes_rsp_valid arrives -> all outputs at reset values, err=1; the next start clears err.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared types and helpers for the streaming GCTR datapath.
// Counter increment and tail masking live here so every stage agrees.
package gcm_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } state_e;

  // Low s bits wrap modulo 2^s; upper bits never see a carry.
  function automatic logic [BLOCK_W-1:0] inc_s(
    input logic [BLOCK_W-1:0] cb,
    input int                 s
  );
    logic [BLOCK_W-1:0] m;
    if (s >= BLOCK_W) m = '1;
    else              m = (128'd1 << s) - 128'd1;
    return (cb & ~m) | ((cb + 128'd1) & m);
  endfunction

  // Keep the top nbits of blk, zero the rest.
  function automatic logic [BLOCK_W-1:0] mask_tail(
    input logic [BLOCK_W-1:0] blk,
    input logic [7:0]         nbits
  );
    logic [BLOCK_W-1:0] m;
    if (nbits >= 8'd128) m = '1;
    else                 m = ~({BLOCK_W{1'b1}} >> nbits);
    return blk & m;
  endfunction

endpackage

// File: rtl/gctr_fifo.sv
// Small synchronous FIFO with occupancy count.
// Used for both plaintext holding and finished ciphertext.
module gctr_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      wr_d  = wr_q + AW'(1);
      cnt_d = cnt_d + (AW+1)'(1);
    end
    if (pop_ok) begin
      rd_d  = rd_q + AW'(1);
      cnt_d = cnt_d - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/gctr_stream.sv
// Streaming GCTR: counter generation, AES request issue, keystream XOR.
// In-flight credit equals data FIFO plus output FIFO occupancy.
module gctr_stream
  import gcm_pkg::*;
#(
  parameter int S         = 32,
  parameter int LEN_WIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [127:0]         icb_in,
  input  logic [LEN_WIDTH-1:0] msg_len_bits,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [127:0]         din,
  output logic                 aes_req_valid,
  input  logic                 aes_req_ready,
  output logic [127:0]         aes_req_block,
  input  logic                 aes_rsp_valid,
  input  logic [127:0]         aes_rsp_block,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [127:0]         dout,
  output logic                 dout_last,
  output logic [7:0]           dout_nbits,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int BW = LEN_WIDTH - 6;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = BLOCK_W + 1 + 8;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e         state_q, state_d;
  logic [127:0]   cb_q, cb_d;
  logic [BW-1:0]  nblk_q, nblk_d;
  logic [BW-1:0]  acc_q, acc_d;
  logic [BW-1:0]  rsp_q, rsp_d;
  logic [6:0]     rem_q, rem_d;
  logic           err_q, err_d;

  logic [BW-1:0]  nblk_in;
  logic           accept;
  logic           rsp_ok;
  logic           stray;
  logic           rsp_last;
  logic [7:0]     y_nbits;
  logic [127:0]   y;
  logic           opop;

  logic [127:0]   x_head;
  logic           dfull, dempty;
  logic [CW-1:0]  dcnt;
  logic [OW-1:0]  o_head;
  logic           ofull, oempty;
  logic [CW-1:0]  ocnt;
  logic [CW-1:0]  inflight;

  assign nblk_in = {1'b0, msg_len_bits[LEN_WIDTH-1:7]}
                 + {{(BW-1){1'b0}}, |msg_len_bits[6:0]};

  assign inflight      = dcnt + ocnt;
  assign aes_req_valid = din_ready && din_valid;
  assign aes_req_block = cb_q;
  assign accept        = aes_req_valid;

  // Responses are in order, so the data FIFO count is the outstanding count.
  assign rsp_ok   = aes_rsp_valid && !dempty;
  assign stray    = aes_rsp_valid && dempty;
  assign rsp_last = (rsp_q == nblk_q - BW'(1));
  assign y_nbits  = (rsp_last && rem_q != 7'd0) ? {1'b0, rem_q} : 8'd128;
  assign y        = mask_tail(x_head ^ aes_rsp_block, y_nbits);

  assign dout_valid = !oempty;
  assign dout       = oempty ? '0 : o_head[127:0];
  assign dout_nbits = oempty ? '0 : o_head[135:128];
  assign dout_last  = oempty ? 1'b0 : o_head[136];
  assign opop       = dout_valid && dout_ready;
  assign err        = err_q;

  gctr_fifo #(.WIDTH(BLOCK_W), .DEPTH(DEPTH)) u_dfifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .din_i   (din),
    .pop_i   (rsp_ok),
    .dout_o  (x_head),
    .full_o  (dfull),
    .empty_o (dempty),
    .count_o (dcnt)
  );

  gctr_fifo #(.WIDTH(OW), .DEPTH(DEPTH)) u_ofifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_ok && !ofull),
    .din_i   ({rsp_last, y_nbits, y}),
    .pop_i   (opop),
    .dout_o  (o_head),
    .full_o  (ofull),
    .empty_o (oempty),
    .count_o (ocnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cb_q    <= '0;
      nblk_q  <= '0;
      acc_q   <= '0;
      rsp_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cb_q    <= cb_d;
      nblk_q  <= nblk_d;
      acc_q   <= acc_d;
      rsp_q   <= rsp_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cb_d    = cb_q;
    nblk_d  = nblk_q;
    acc_d   = acc_q;
    rsp_d   = rsp_ok ? rsp_q + BW'(1) : rsp_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cb_d    = icb_in;
          nblk_d  = nblk_in;
          rem_d   = msg_len_bits[6:0];
          acc_d   = '0;
          rsp_d   = '0;
          state_d = (nblk_in == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          cb_d  = inc_s(cb_q, S);
          acc_d = acc_q + BW'(1);
          if (acc_q == nblk_q - BW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (opop && dout_last) state_d = ST_FIN;
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A stray response in the same cycle as start still flags.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && start) err_d = 1'b0;
    if (stray) err_d = 1'b1;
  end

  always_comb begin
    din_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE:  ;
      ST_RUN: begin
        busy      = 1'b1;
        din_ready = aes_req_ready && (inflight < DEPTH_C) && !dfull;
      end
      ST_DRAIN: busy = 1'b1;
      ST_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gctr_stream.sv
// Directed bench for gctr_stream with a 3-cycle in-order AES stand-in.
// Keystream for CB 1..4 (zero upper bits) is taken from the NIST GCM TC3 vectors.
module tb_gctr_stream;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] icb_in = '0;
  logic [31:0]  msg_len_bits = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [127:0] din = '0;
  logic         aes_req_valid;
  logic         aes_req_ready = 1'b1;
  logic [127:0] aes_req_block;
  logic         aes_rsp_valid;
  logic [127:0] aes_rsp_block;
  logic         dout_valid;
  logic         dout_ready = 1'b1;
  logic [127:0] dout;
  logic         dout_last;
  logic [7:0]   dout_nbits;
  logic         busy, done, err;

  always #5 clk = ~clk;

  gctr_stream dut (
    .clk(clk), .rst(rst), .start(start), .icb_in(icb_in),
    .msg_len_bits(msg_len_bits), .din_valid(din_valid),
    .din_ready(din_ready), .din(din), .aes_req_valid(aes_req_valid),
    .aes_req_ready(aes_req_ready), .aes_req_block(aes_req_block),
    .aes_rsp_valid(aes_rsp_valid), .aes_rsp_block(aes_rsp_block),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .dout_last(dout_last), .dout_nbits(dout_nbits), .busy(busy),
    .done(done), .err(err)
  );

  typedef struct {
    logic [127:0] d;
    logic         l;
    logic [7:0]   nb;
  } out_t;

  logic [127:0] P [4];
  logic [127:0] C [4];
  logic [127:0] blk [16];
  logic [127:0] reqs [$];
  out_t         outs [$];
  int           done_cnt = 0;
  int           d0 = 0;
  int           total = 0;
  int           bad = 0;

  logic         pv [3];
  logic [127:0] pb [3];
  logic         inj = 1'b0;

  assign aes_rsp_valid = pv[2] | inj;
  assign aes_rsp_block = pb[2];

  function automatic logic [127:0] ks_of(input logic [127:0] cb);
    if (cb[127:32] == 96'h0 && cb[31:0] >= 1 && cb[31:0] <= 4)
      return P[cb[1:0] - 2'd1] ^ C[cb[1:0] - 2'd1];
    return {cb[63:0], cb[127:64]} ^ 128'h0123456789abcdeffedcba9876543210;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        pv[i] <= 1'b0;
        pb[i] <= '0;
      end
    end else begin
      pv[2] <= pv[1];
      pb[2] <= pb[1];
      pv[1] <= pv[0];
      pb[1] <= pb[0];
      pv[0] <= aes_req_valid && aes_req_ready;
      pb[0] <= ks_of(aes_req_block);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (aes_req_valid && aes_req_ready) reqs.push_back(aes_req_block);
      if (dout_valid && dout_ready) outs.push_back('{dout, dout_last, dout_nbits});
      if (done) done_cnt++;
    end
  end

  task automatic start_op(input logic [127:0] icb, input logic [31:0] len);
    reqs.delete();
    outs.delete();
    d0 = done_cnt;
    icb_in = icb;
    msg_len_bits = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    int i = 0;
    int t = 0;
    while (i < n && t < 400) begin
      din_valid = 1'b1;
      din = blk[i];
      @(negedge clk);
      if (din_ready) i++;
      @(posedge clk); #1;
      t++;
    end
    din_valid = 1'b0;
    din = '0;
    total++;
    if (i != n) begin
      bad++;
      $display("FAIL feed accepted=%0d required=%0d", i, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done_cnt == d0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL done_timeout waited=%0d cycles", t);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({din_ready, aes_req_valid, dout_valid, dout_last} !== 4'b0) begin
      bad++;
      $display("FAIL reset_handshake got=%b required=0000",
               {din_ready, aes_req_valid, dout_valid, dout_last});
    end
    total++;
    if ({busy, done, err} !== 3'b0) begin
      bad++;
      $display("FAIL reset_status got=%b required=000", {busy, done, err});
    end
    total++;
    if (aes_req_block !== '0 || dout !== '0 || dout_nbits !== 8'd0) begin
      bad++;
      $display("FAIL reset_data req=%h dout=%h nbits=%0d required zeros",
               aes_req_block, dout, dout_nbits);
    end
  endtask

  task automatic test_nist_tc3;
    for (int i = 0; i < 3; i++) blk[i] = P[i];
    start_op(128'h1, 32'd384);
    feed(3);
    wait_done(100);
    total++;
    if (outs.size() != 3 || reqs.size() != 3) begin
      bad++;
      $display("FAIL tc3_count outs=%0d reqs=%0d required=3", outs.size(), reqs.size());
    end
    for (int i = 0; i < 3 && i < outs.size() && i < reqs.size(); i++) begin
      total++;
      if (reqs[i] !== 128'(i + 1)) begin
        bad++;
        $display("FAIL tc3_cb%0d got=%h required=%h", i, reqs[i], 128'(i + 1));
      end
      total++;
      if (outs[i].d !== C[i] || outs[i].l !== (i == 2) || outs[i].nb !== 8'd128) begin
        bad++;
        $display("FAIL tc3_y%0d got=%h last=%b nb=%0d required=%h last=%b nb=128",
                 i, outs[i].d, outs[i].l, outs[i].nb, C[i], (i == 2));
      end
    end
    total++;
    if (done_cnt != d0 + 1) begin
      bad++;
      $display("FAIL tc3_done_pulses got=%0d required=1", done_cnt - d0);
    end
  endtask

  task automatic test_partial;
    blk[0] = P[0];
    start_op(128'h1, 32'd100);
    feed(1);
    wait_done(100);
    total++;
    if (outs.size() != 1) begin
      bad++;
      $display("FAIL partial_count got=%0d required=1", outs.size());
    end else begin
      total++;
      if (outs[0].d !== 128'h42831ec2217774244b7221b780000000) begin
        bad++;
        $display("FAIL partial_y got=%h required=42831ec2217774244b7221b780000000",
                 outs[0].d);
      end
      total++;
      if (outs[0].nb !== 8'd100 || outs[0].l !== 1'b1 || outs[0].d[27:0] !== 28'h0) begin
        bad++;
        $display("FAIL partial_meta nb=%0d last=%b low=%h required nb=100 last=1 low=0",
                 outs[0].nb, outs[0].l, outs[0].d[27:0]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [127:0] cbx [4];
    cbx[0] = 128'hcafebabefacedbaddecaf888fffffffe;
    cbx[1] = 128'hcafebabefacedbaddecaf888ffffffff;
    cbx[2] = 128'hcafebabefacedbaddecaf88800000000;
    cbx[3] = 128'hcafebabefacedbaddecaf88800000001;
    for (int i = 0; i < 4; i++) blk[i] = P[i];
    start_op(cbx[0], 32'd512);
    feed(4);
    wait_done(100);
    total++;
    if (reqs.size() != 4 || outs.size() != 4) begin
      bad++;
      $display("FAIL wrap_count reqs=%0d outs=%0d required=4", reqs.size(), outs.size());
    end
    for (int i = 0; i < 4 && i < reqs.size() && i < outs.size(); i++) begin
      total++;
      if (reqs[i] !== cbx[i]) begin
        bad++;
        $display("FAIL wrap_cb%0d got=%h required=%h", i, reqs[i], cbx[i]);
      end
      total++;
      if (outs[i].d !== (P[i] ^ ks_of(cbx[i]))) begin
        bad++;
        $display("FAIL wrap_y%0d got=%h required=%h", i, outs[i].d, P[i] ^ ks_of(cbx[i]));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] icb = {96'h1, 32'h10};
    for (int i = 0; i < 8; i++) blk[i] = {4{32'(i) * 32'h11111111}};
    dout_ready = 1'b0;
    start_op(icb, 32'd1024);
    fork
      feed(8);
      begin
        repeat (20) @(negedge clk);
        total++;
        if (reqs.size() != 4 || din_ready !== 1'b0 || dout_valid !== 1'b1) begin
          bad++;
          $display("FAIL stall accepts=%0d din_ready=%b dout_valid=%b required 4/0/1",
                   reqs.size(), din_ready, dout_valid);
        end
        @(posedge clk); #1;
        dout_ready = 1'b1;
      end
    join
    wait_done(200);
    total++;
    if (outs.size() != 8) begin
      bad++;
      $display("FAIL stall_count got=%0d required=8", outs.size());
    end
    for (int i = 0; i < 8 && i < outs.size(); i++) begin
      total++;
      if (outs[i].d !== (blk[i] ^ ks_of(icb + 128'(i))) || outs[i].l !== (i == 7)) begin
        bad++;
        $display("FAIL stall_y%0d got=%h last=%b required=%h", i, outs[i].d,
                 outs[i].l, blk[i] ^ ks_of(icb + 128'(i)));
      end
    end
  endtask

  task automatic test_zero_len;
    logic [127:0] icb = {96'h7, 32'h0};
    start_op(128'h5, 32'd0);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL zero_done got=%b required=1", done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || reqs.size() != 0) begin
      bad++;
      $display("FAIL zero_after done=%b reqs=%0d required 0/0", done, reqs.size());
    end
    @(posedge clk); #1;
    blk[0] = P[0];
    blk[1] = P[1];
    start_op(icb, 32'd256);
    icb_in = 128'h3;
    msg_len_bits = 32'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(2);
    wait_done(100);
    total++;
    if (reqs.size() != 2 || outs.size() != 2 || done_cnt != d0 + 1) begin
      bad++;
      $display("FAIL busy_start reqs=%0d outs=%0d dones=%0d required 2/2/1",
               reqs.size(), outs.size(), done_cnt - d0);
    end else begin
      total++;
      if (reqs[1] !== icb + 128'd1 || outs[1].d !== (P[1] ^ ks_of(icb + 128'd1))) begin
        bad++;
        $display("FAIL busy_start_data cb=%h y=%h required cb=%h", reqs[1],
                 outs[1].d, icb + 128'd1);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) blk[i] = P[i];
    start_op({96'h5, 32'h0}, 32'd1024);
    feed(3);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({din_ready, aes_req_valid, dout_valid, busy, done, err} !== 6'b0
        || aes_req_block !== '0 || dout !== '0) begin
      bad++;
      $display("FAIL midrst_outputs flags=%b req=%h dout=%h required zeros",
               {din_ready, aes_req_valid, dout_valid, busy, done, err},
               aes_req_block, dout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b1 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL stale_rsp err=%b dout_valid=%b required 1/0", err, dout_valid);
    end
    @(posedge clk); #1;
    start_op('0, 32'd0);
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b required=0", err);
    end
    wait_done(20);
  endtask

  initial begin
    P[0] = 128'hd9313225f88406e5a55909c5aff5269a;
    P[1] = 128'h86a7a9531534f7da2e4c303d8a318a72;
    P[2] = 128'h1c3c0c95956809532fcf0e2449a6b525;
    P[3] = 128'hb16aedf5aa0de657ba637b391aafd255;
    C[0] = 128'h42831ec2217774244b7221b784d0d49c;
    C[1] = 128'he3aa212f2c02a4e035c17e2329aca12e;
    C[2] = 128'h21d514b25466931c7d8f6a5aac84aa05;
    C[3] = 128'h1ba30b396a0aac973d58e091473f5985;
    for (int i = 0; i < 16; i++) blk[i] = '0;
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_nist_tc3();
    test_partial();
    test_wrap();
    test_back_to_back();
    test_zero_len();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
